// File: rtl/armleocpu_regfile_reader_pkg.sv
// Shared state encodings for the register-file read sequencer.
package armleocpu_regfile_reader_pkg;

  typedef enum logic [2:0] {
    StClear,
    StIdle,
    StRd2,
    StCap,
    StResp
  } rdr_state_e;

endpackage

// File: rtl/armleocpu_regfile_reader.sv
// Register-file read sequencer: clears the storage lane after reset, then serves two-operand
// reads over a single read port while letting writebacks through to the write port.
module armleocpu_regfile_reader
  import armleocpu_regfile_reader_pkg::*;
#(
  parameter int unsigned ELEMENTS_W = 5,
  parameter int unsigned WIDTH      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,

  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ELEMENTS_W-1:0] req_rs1,
  input  logic [ELEMENTS_W-1:0] req_rs2,

  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [WIDTH-1:0]      rsp_rs1_data,
  output logic [WIDTH-1:0]      rsp_rs2_data,

  input  logic                  wb_valid,
  output logic                  wb_ready,
  input  logic [ELEMENTS_W-1:0] wb_rd,
  input  logic [WIDTH-1:0]      wb_data,

  output logic [ELEMENTS_W-1:0] rf_readaddress,
  output logic                  rf_read,
  input  logic [WIDTH-1:0]      rf_readdata,
  output logic [ELEMENTS_W-1:0] rf_writeaddress,
  output logic                  rf_write,
  output logic [WIDTH-1:0]      rf_writedata,

  output logic                  init_done
);

  localparam logic [ELEMENTS_W-1:0] LastAddr = '1;

  rdr_state_e            state_q, state_d;
  logic [ELEMENTS_W-1:0] cnt_q, cnt_d;
  logic [ELEMENTS_W-1:0] rs1_q, rs1_d, rs2_q, rs2_d;
  logic [WIDTH-1:0]      rs1_data_q, rs1_data_d, rs2_data_q, rs2_data_d;
  logic [WIDTH-1:0]      byp_data_q, byp_data_d;
  logic                  byp_valid_q, byp_valid_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic                  wb_fire;

  assign req_ready    = (state_q == StIdle);
  assign wb_ready     = (state_q != StClear);
  assign init_done    = (state_q != StClear);
  assign wb_fire      = wb_valid & wb_ready;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_rs1_data = rs1_data_q;
  assign rsp_rs2_data = rs2_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      cnt_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      byp_data_q  <= '0;
      byp_valid_q <= 1'b0;
      rsp_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rs1_data_q  <= rs1_data_d;
      rs2_data_q  <= rs2_data_d;
      byp_data_q  <= byp_data_d;
      byp_valid_q <= byp_valid_d;
      rsp_valid_q <= rsp_valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rs1_data_d  = rs1_data_q;
    rs2_data_d  = rs2_data_q;
    byp_data_d  = byp_data_q;
    byp_valid_d = byp_valid_q;
    rsp_valid_d = rsp_valid_q;
    unique case (state_q)
      StClear: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == LastAddr) state_d = StIdle;
      end
      StIdle: begin
        if (req_valid) begin
          rs1_d       = req_rs1;
          rs2_d       = req_rs2;
          // The rs1 read this cycle sees pre-write data, so remember a same-cycle writeback.
          byp_valid_d = wb_fire && (wb_rd == req_rs1);
          byp_data_d  = wb_data;
          state_d     = StRd2;
        end
      end
      StRd2: begin
        if (rs1_q == '0)     rs1_data_d = '0;
        else if (byp_valid_q) rs1_data_d = byp_data_q;
        else                  rs1_data_d = rf_readdata;
        state_d = StCap;
      end
      StCap: begin
        rs2_data_d  = (rs2_q == '0) ? '0 : rf_readdata;
        rsp_valid_d = 1'b1;
        state_d     = StResp;
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StClear;
    endcase
  end

  always_comb begin
    rf_read        = 1'b0;
    rf_readaddress = req_rs1;
    if ((state_q == StIdle) && req_valid) rf_read = 1'b1;
    if (state_q == StRd2) begin
      rf_read        = 1'b1;
      rf_readaddress = rs2_q;
    end
    if (state_q == StClear) begin
      rf_write        = 1'b1;
      rf_writeaddress = cnt_q;
      rf_writedata    = '0;
    end else begin
      rf_write        = wb_fire && (wb_rd != '0);
      rf_writeaddress = wb_rd;
      rf_writedata    = wb_data;
    end
  end

endmodule

// File: tb/tb_armleocpu_regfile_reader.sv
// Directed bench for armleocpu_regfile_reader with a behavioural storage lane.
module tb_armleocpu_regfile_reader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid, req_ready, rsp_valid, rsp_ready;
  logic [4:0]  req_rs1, req_rs2, wb_rd, rf_readaddress, rf_writeaddress;
  logic [31:0] rsp_rs1_data, rsp_rs2_data, wb_data, rf_readdata, rf_writedata;
  logic        wb_valid, wb_ready, rf_read, rf_write, init_done;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [32];
  logic        prefill = 1'b1;

  always #5 clk = ~clk;

  // Storage lane: registered read-before-write; address 0 returns junk so zero forcing is visible.
  always @(posedge clk) begin
    if (prefill) begin
      for (int i = 0; i < 32; i++) mem[i] <= 32'hBAD0_0000 | 32'(i);
    end else begin
      if (rf_read) rf_readdata <= (rf_readaddress == 5'd0) ? 32'hFFFF_FFFF : mem[rf_readaddress];
      if (rf_write) mem[rf_writeaddress] <= rf_writedata;
    end
  end

  armleocpu_regfile_reader #(.ELEMENTS_W(5), .WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_rs1        (req_rs1),
    .req_rs2        (req_rs2),
    .rsp_valid      (rsp_valid),
    .rsp_ready      (rsp_ready),
    .rsp_rs1_data   (rsp_rs1_data),
    .rsp_rs2_data   (rsp_rs2_data),
    .wb_valid       (wb_valid),
    .wb_ready       (wb_ready),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .rf_readaddress (rf_readaddress),
    .rf_read        (rf_read),
    .rf_readdata    (rf_readdata),
    .rf_writeaddress(rf_writeaddress),
    .rf_write       (rf_write),
    .rf_writedata   (rf_writedata),
    .init_done      (init_done)
  );

  // Drives one request from a negedge in the accept cycle N; returns at mid N+3.
  task automatic do_req(input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic w0v, input logic [4:0] w0rd, input logic [31:0] w0d,
                        input logic w1v, input logic [4:0] w1rd, input logic [31:0] w1d,
                        output logic rdy, output logic rd0, output logic [4:0] ra0,
                        output logic v1, output logic v2, output logic v3,
                        output logic [31:0] d1, output logic [31:0] d2);
    rdy = req_ready;
    req_valid = 1'b1; req_rs1 = rs1; req_rs2 = rs2;
    wb_valid = w0v; wb_rd = w0rd; wb_data = w0d;
    #1;
    rd0 = rf_read; ra0 = rf_readaddress;
    @(negedge clk);
    req_valid = 1'b0;
    wb_valid = w1v; wb_rd = w1rd; wb_data = w1d;
    v1 = rsp_valid;
    @(negedge clk);
    wb_valid = 1'b0;
    v2 = rsp_valid;
    @(negedge clk);
    v3 = rsp_valid; d1 = rsp_rs1_data; d2 = rsp_rs2_data;
  endtask

  task automatic consume();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  logic        r_rdy, r_rd0, r_v1, r_v2, r_v3;
  logic [4:0]  r_ra0;
  logic [31:0] r_d1, r_d2;

  task automatic test_reset();
    prefill = 1'b1; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0 || wb_ready !== 1'b0 ||
        rsp_rs1_data !== 32'd0 || rsp_rs2_data !== 32'd0) begin
      errors++;
      $display("FAIL reset_state: rsp_valid=%b init_done=%b req_ready=%b wb_ready=%b d1=%h d2=%h, expected all 0",
               rsp_valid, init_done, req_ready, wb_ready, rsp_rs1_data, rsp_rs2_data);
    end
    prefill = 1'b0; rst_n = 1'b1;
    req_valid = 1'b1; req_rs1 = 5'd4; wb_valid = 1'b1; wb_rd = 5'd9; wb_data = 32'h5555_AAAA;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (rf_write !== 1'b1 || rf_writeaddress !== 5'(i) || rf_writedata !== 32'd0 ||
          rf_read !== 1'b0 || req_ready !== 1'b0 || wb_ready !== 1'b0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL clear_cycle_%0d: we=%b wa=%0d wd=%h rd=%b req_ready=%b wb_ready=%b init=%b, expected we=1 wa=%0d wd=0 others 0",
                 i, rf_write, rf_writeaddress, rf_writedata, rf_read, req_ready, wb_ready, init_done, i);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; wb_valid = 1'b0;
    #1;
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1 || rf_write !== 1'b0) begin
      errors++;
      $display("FAIL clear_done: init_done=%b req_ready=%b rf_write=%b, expected 1 1 0",
               init_done, req_ready, rf_write);
    end
    @(negedge clk);
  endtask

  task automatic test_wb_read();
    wb_valid = 1'b1; wb_rd = 5'd5; wb_data = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (rf_write !== 1'b1 || rf_writeaddress !== 5'd5 || rf_writedata !== 32'hDEAD_BEEF || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_x5: we=%b wa=%0d wd=%h ready=%b, expected 1 5 deadbeef 1",
               rf_write, rf_writeaddress, rf_writedata, wb_ready);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    do_req(5'd5, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_rdy !== 1'b1 || r_rd0 !== 1'b1 || r_ra0 !== 5'd5) begin
      errors++;
      $display("FAIL accept_cycle: ready=%b rf_read=%b addr=%0d, expected 1 1 5", r_rdy, r_rd0, r_ra0);
    end
    checks++;
    if (r_v1 !== 1'b0 || r_v2 !== 1'b0 || r_v3 !== 1'b1) begin
      errors++;
      $display("FAIL latency: rsp_valid N+1..N+3=%b%b%b, expected 001", r_v1, r_v2, r_v3);
    end
    checks++;
    if (r_d1 !== 32'hDEAD_BEEF || r_d2 !== 32'd0) begin
      errors++;
      $display("FAIL read_5_0: got %h %h, expected deadbeef 00000000", r_d1, r_d2);
    end
    consume();
    do_req(5'd0, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_v3 !== 1'b1 || r_d1 !== 32'd0 || r_d2 !== 32'hDEAD_BEEF) begin
      errors++;
      $display("FAIL read_0_5: valid=%b got %h %h, expected 1 00000000 deadbeef", r_v3, r_d1, r_d2);
    end
    consume();
  endtask

  task automatic test_bypass();
    do_req(5'd7, 5'd7, 1'b1, 5'd7, 32'h1234_5678, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_v3 !== 1'b1 || r_d1 !== 32'h1234_5678 || r_d2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL bypass_7_7: valid=%b got %h %h, expected 1 12345678 12345678", r_v3, r_d1, r_d2);
    end
    consume();
  endtask

  task automatic test_late_wb();
    do_req(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hAAAA_5555,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'd0 || r_d2 !== 32'd0) begin
      errors++;
      $display("FAIL late_wb_rs1: got %h %h, expected 00000000 00000000", r_d1, r_d2);
    end
    consume();
    do_req(5'd3, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL after_late_wb: got %h, expected aaaa5555", r_d1);
    end
    consume();
    do_req(5'd0, 5'd9, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h0BAD_F00D,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d2 !== 32'd0) begin
      errors++;
      $display("FAIL late_wb_rs2: got %h, expected 00000000", r_d2);
    end
    consume();
    do_req(5'd9, 5'd9, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'h0BAD_F00D || r_d2 !== 32'h0BAD_F00D) begin
      errors++;
      $display("FAIL read_9_9: got %h %h, expected 0badf00d 0badf00d", r_d1, r_d2);
    end
    consume();
  endtask

  task automatic test_x0();
    wb_valid = 1'b1; wb_rd = 5'd0; wb_data = 32'hFFFF_FFFF;
    #1;
    checks++;
    if (rf_write !== 1'b0 || wb_ready !== 1'b1) begin
      errors++;
      $display("FAIL wb_x0: rf_write=%b wb_ready=%b, expected 0 1", rf_write, wb_ready);
    end
    @(negedge clk);
    wb_valid = 1'b0;
    do_req(5'd0, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'd0 || r_d2 !== 32'd0) begin
      errors++;
      $display("FAIL read_0_0: got %h %h, expected 00000000 00000000", r_d1, r_d2);
    end
    consume();
    do_req(5'd0, 5'd3, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'd0 || r_d2 !== 32'hAAAA_5555) begin
      errors++;
      $display("FAIL x0_bypass: got %h %h, expected 00000000 aaaa5555", r_d1, r_d2);
    end
    consume();
  endtask

  task automatic test_backpressure();
    do_req(5'd5, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'hDEAD_BEEF || r_d2 !== 32'h1234_5678) begin
      errors++;
      $display("FAIL read_5_7: got %h %h, expected deadbeef 12345678", r_d1, r_d2);
    end
    req_valid = 1'b1; req_rs1 = 5'd1; req_rs2 = 5'd2;
    wb_valid = 1'b1; wb_rd = 5'd7; wb_data = 32'h1111_1111;
    for (int k = 0; k < 5; k++) begin
      #1;
      checks++;
      if (rsp_valid !== 1'b1 || rsp_rs1_data !== 32'hDEAD_BEEF || rsp_rs2_data !== 32'h1234_5678 ||
          req_ready !== 1'b0 || rf_read !== 1'b0) begin
        errors++;
        $display("FAIL stall_%0d: valid=%b d=%h %h req_ready=%b rf_read=%b, expected 1 deadbeef 12345678 0 0",
                 k, rsp_valid, rsp_rs1_data, rsp_rs2_data, req_ready, rf_read);
      end
      @(negedge clk);
    end
    req_valid = 1'b0; wb_valid = 1'b0;
    consume();
    #1;
    checks++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL after_consume: req_ready=%b rsp_valid=%b, expected 1 0", req_ready, rsp_valid);
    end
    @(negedge clk);
    do_req(5'd7, 5'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_d1 !== 32'h1111_1111) begin
      errors++;
      $display("FAIL wb_in_resp: got %h, expected 11111111", r_d1);
    end
    consume();
  endtask

  task automatic test_reset_in_resp();
    do_req(5'd5, 5'd5, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    rst_n = 1'b0;
    #1;
    checks++;
    if (rsp_valid !== 1'b0 || rsp_rs1_data !== 32'd0 || rsp_rs2_data !== 32'd0 ||
        init_done !== 1'b0 || req_ready !== 1'b0 || wb_ready !== 1'b0) begin
      errors++;
      $display("FAIL async_reset: valid=%b d=%h %h init=%b req_ready=%b wb_ready=%b, expected all 0",
               rsp_valid, rsp_rs1_data, rsp_rs2_data, init_done, req_ready, wb_ready);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      #1;
      checks++;
      if (rf_write !== 1'b1 || rf_writeaddress !== 5'(i) || rf_writedata !== 32'd0 || init_done !== 1'b0) begin
        errors++;
        $display("FAIL reclear_cycle_%0d: we=%b wa=%0d wd=%h init=%b, expected 1 %0d 0 0",
                 i, rf_write, rf_writeaddress, rf_writedata, init_done, i);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (init_done !== 1'b1 || req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reclear_done: init_done=%b req_ready=%b, expected 1 1", init_done, req_ready);
    end
    @(negedge clk);
    do_req(5'd5, 5'd7, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0,
           r_rdy, r_rd0, r_ra0, r_v1, r_v2, r_v3, r_d1, r_d2);
    checks++;
    if (r_v3 !== 1'b1 || r_d1 !== 32'd0 || r_d2 !== 32'd0) begin
      errors++;
      $display("FAIL read_after_reclear: valid=%b got %h %h, expected 1 00000000 00000000", r_v3, r_d1, r_d2);
    end
    consume();
  endtask

  initial begin
    req_valid = 1'b0; req_rs1 = '0; req_rs2 = '0; rsp_ready = 1'b0;
    wb_valid = 1'b0; wb_rd = '0; wb_data = '0;
    @(negedge clk);
    test_reset();
    test_wb_read();
    test_bypass();
    test_late_wb();
    test_x0();
    test_backpressure();
    test_reset_in_resp();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/armleocpu_regfile_reader.md
ARMLEOCPU_REGFILE_READER -- requirements
Module: armleocpu_regfile_reader

Interface
REQ-001 SHALL have parameters: ELEMENTS_W, 5, register-address width (2**ELEMENTS_W entries); WIDTH, 32, data width.
REQ-002 SHALL have one clock and asynchronous active-low reset:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
REQ-003 SHALL have the request port:
- req_valid  in  1  read request
- req_ready  out  1  request accepted when high with req_valid
- req_rs1, req_rs2  in  ELEMENTS_W  source addresses
REQ-004 SHALL have the response port:
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rs1_data, rsp_rs2_data  out  WIDTH  operand data
REQ-005 SHALL have the writeback port:
- wb_valid  in  1  write request
- wb_ready  out  1  write accepted when high with wb_valid
- wb_rd  in  ELEMENTS_W  destination address
- wb_data  in  WIDTH  write data
REQ-006 SHALL drive an external storage lane (one write port, one read port, 1-cycle registered read with read-before-write, readdata held between reads):
- rf_readaddress  out  ELEMENTS_W
- rf_read  out  1
- rf_readdata  in  WIDTH
- rf_writeaddress  out  ELEMENTS_W
- rf_write  out  1
- rf_writedata  out  WIDTH
REQ-007 SHALL have init_done  out  1: high once CLEAR completes.

Function
REQ-008 SHALL implement FSM states CLEAR, IDLE, RD2, CAP, RESP.
REQ-009 CLEAR: rf_write=1, rf_writeaddress=counter, rf_writedata=0; counter increments 0..2**ELEMENTS_W-1; exit to IDLE after the last entry, i.e. 2**ELEMENTS_W cycles after reset release.
REQ-010 CLEAR: req_ready=0, wb_ready=0, init_done=0, rf_read=0.
REQ-011 wb_ready SHALL be 1 in every state except CLEAR.
REQ-012 Outside CLEAR, rf_write SHALL equal wb_valid & wb_ready & (wb_rd!=0), with rf_writeaddress=wb_rd and rf_writedata=wb_data, combinationally; writes to address 0 are accepted and dropped.
REQ-013 req_ready SHALL be 1 only in IDLE.
REQ-014 Accept cycle N (IDLE, req_valid=1): latch rs1/rs2; rf_read=1 with rf_readaddress=req_rs1; go to RD2.
REQ-015 RD2 (N+1): capture rs1 data; rf_read=1 with rf_readaddress=rs2_q; go to CAP.
REQ-016 CAP (N+2): capture rs2 data; go to RESP; rsp_valid registered high from N+3.
REQ-017 RESP: hold rsp_valid and data stable until rsp_valid & rsp_ready; then go to IDLE (next accept no earlier than that following cycle).
REQ-018 Snapshot rule: response data SHALL reflect all writebacks accepted in cycles <= N and none after N.
REQ-019 Bypass: a writeback to latched rs1 (nonzero) accepted in cycle N SHALL replace captured rs1 data with its wb_data; a writeback in N+1 or later SHALL NOT alter the response.
REQ-020 Address 0: captured data SHALL be 0 regardless of rf_readdata.
REQ-021 rs1==rs2 SHALL be legal and return identical data.
REQ-022 rf_read SHALL be 0 outside the accept cycle and RD2.

Reset
REQ-023 On rst_n low, asynchronously: state=CLEAR, counter=0, rsp_valid=0, rsp data=0, init_done=0, req_ready=0, wb_ready=0.
REQ-024 Reset during any state SHALL discard the pending request and re-run the full CLEAR sequence.

Structure
REQ-025 SHALL place the FSM state encodings in the shared armleocpu defines package; ELEMENTS_W and WIDTH stay module parameters.
REQ-026 SHALL be a single module with no sub-module; the storage lane is instantiated by the parent.

Verification
REQ-027 Reset release: 32 writes of 0 to addresses 0..31; init_done=1, req_ready=1 in cycle 33.
REQ-028 wb x5=0xDEADBEEF, then request rs1=5, rs2=0 -> rsp_valid at N+3 with 0xDEADBEEF and 0x00000000.
REQ-029 Request rs1=rs2=7 with wb x7=0x12345678 in the accept cycle -> both operands 0x12345678.
REQ-030 wb x3=0xAAAA5555 in N+1 after a request for rs1=3 -> rs1 returns the old value 0; a following request returns 0xAAAA5555.
REQ-031 wb x0=0xFFFFFFFF, then read rs1=0 -> 0; rf_write stays 0 for that writeback.
REQ-032 rsp_ready held low 5 cycles -> rsp data stable, req_ready=0; rst_n pulse in RESP -> rsp_valid=0 immediately and CLEAR restarts.
